// File: rtl/skew_align_buffer.sv
// Per-lane skew/deskew delay line for systolic array edges, with per-lane valid tracking,
// a counted flush/drain engine and a global hold for back-pressure.
module skew_align_buffer #(
    parameter int unsigned          SA_SIZE         = 8,
    parameter int unsigned          ACTIVATION_SIZE = 32,
    parameter bit                   SKEW_DIR        = 1'b0,
    parameter int unsigned          EXTRA_DELAY     = 0,
    parameter int unsigned          CMD_WIDTH       = 3,
    parameter logic [CMD_WIDTH-1:0] CMD_STREAM      = CMD_WIDTH'(1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CMD_WIDTH-1:0]       cmd_i,
    input  logic                       hold_i,
    input  logic                       flush_i,
    input  logic [SA_SIZE-1:0]         in_valid_i,
    input  logic [ACTIVATION_SIZE-1:0] inputs_i [SA_SIZE],
    output logic [ACTIVATION_SIZE-1:0] out_o [SA_SIZE],
    output logic [SA_SIZE-1:0]         out_valid_o,
    output logic                       all_valid_o,
    output logic                       busy_o
);

    localparam int unsigned LMAX   = SA_SIZE + EXTRA_DELAY;
    localparam int unsigned DrainW = $clog2(LMAX + 1);

    logic              stream;
    logic              draining;
    logic              adv;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

    always_comb begin
        stream   = (cmd_i == CMD_STREAM);
        draining = (drain_cnt_q != '0);
        adv      = ~hold_i & (stream | draining);
    end

    // Hold beats everything; a stream command cancels any drain; flush (re)loads the count.
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (hold_i) begin
            drain_cnt_d = drain_cnt_q;
        end else if (stream) begin
            drain_cnt_d = '0;
        end else if (flush_i) begin
            drain_cnt_d = DrainW'(LMAX);
        end else if (draining) begin
            drain_cnt_d = drain_cnt_q - DrainW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    for (genvar c = 0; c < SA_SIZE; c++) begin : g_lane
        localparam int unsigned Base = SKEW_DIR ? unsigned'(c) + 1 : SA_SIZE - unsigned'(c);
        localparam int unsigned Len  = Base + EXTRA_DELAY;

        logic [ACTIVATION_SIZE-1:0] data_q [Len];
        logic [Len-1:0]             valid_q;

        // Outside a stream command the head of the lane is filled with empty bubbles.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q  <= '{default: '0};
                valid_q <= '0;
            end else if (adv) begin
                data_q[0]  <= stream ? inputs_i[c] : '0;
                valid_q[0] <= stream & in_valid_i[c];
                for (int unsigned r = 1; r < Len; r++) begin
                    data_q[r]  <= data_q[r-1];
                    valid_q[r] <= valid_q[r-1];
                end
            end
        end

        assign out_o[c]       = data_q[Len-1];
        assign out_valid_o[c] = valid_q[Len-1];
    end

    assign all_valid_o = &out_valid_o;
    assign busy_o      = draining;

endmodule
